// File: rtl/fp_pkg.sv
// Shared widths, constants and pipeline payload types for the adder datapath.
package fp_pkg;
  localparam int EXP_W   = 11;
  localparam int SIG_W   = 56;
  localparam int SUM_W   = 57;
  localparam int LZ_W    = 6;
  localparam int EXP_MAX = 2047;

  // Payload captured by the first normalization stage.
  typedef struct packed {
    logic [SUM_W-1:0] fs;
    logic [EXP_W-1:0] es;
    logic             ss;
    logic [LZ_W-1:0]  lz;
    logic             carry;
  } s1_t;

  // Registered result handed to the rounder.
  typedef struct packed {
    logic [SIG_W-1:0] fn;
    logic [EXP_W-1:0] en;
    logic             sn;
    logic             zero;
    logic             ovf;
  } s2_t;
endpackage

// File: rtl/norm_shift_lzc56.sv
// Combinational leading-zero counter for a 56-bit word.
// The word is padded to 64 bits with trailing zeros. 2-bit leaf counters are
// then merged pairwise up a tree. An all-zero input reports 56.
module lzc56 (
  input  logic [55:0] i_data,
  output logic [5:0]  o_count
);
  logic [63:0] w_pad;
  logic        w_v1 [32];
  logic        w_c1 [32];
  logic        w_v2 [16];
  logic [1:0]  w_c2 [16];
  logic        w_v3 [8];
  logic [2:0]  w_c3 [8];
  logic        w_v4 [4];
  logic [3:0]  w_c4 [4];
  logic        w_v5 [2];
  logic [4:0]  w_c5 [2];
  logic        w_v6;
  logic [5:0]  w_c6;

  assign w_pad = {i_data, 8'h00};

  // Leaf level: each node is a 2-bit counter. Node 0 holds the MSBs.
  always_comb begin
    for (int j = 0; j < 32; j++) begin
      w_v1[j] = |w_pad[63-2*j -: 2];
      w_c1[j] = ~w_pad[63-2*j];
    end
  end

  // Merge into 4-bit counters.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_v2[j] = w_v1[2*j] | w_v1[2*j+1];
      w_c2[j] = w_v1[2*j] ? {1'b0, w_c1[2*j]} : {1'b1, w_c1[2*j+1]};
    end
  end

  // Merge into 8-bit counters.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_v3[j] = w_v2[2*j] | w_v2[2*j+1];
      w_c3[j] = w_v2[2*j] ? {1'b0, w_c2[2*j]} : {1'b1, w_c2[2*j+1]};
    end
  end

  // Merge into 16-bit counters.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_v4[j] = w_v3[2*j] | w_v3[2*j+1];
      w_c4[j] = w_v3[2*j] ? {1'b0, w_c3[2*j]} : {1'b1, w_c3[2*j+1]};
    end
  end

  // Merge into 32-bit counters.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_v5[j] = w_v4[2*j] | w_v4[2*j+1];
      w_c5[j] = w_v4[2*j] ? {1'b0, w_c4[2*j]} : {1'b1, w_c4[2*j+1]};
    end
  end

  // Root merge. The padding guarantees a nonzero input counts below 56.
  always_comb begin
    w_v6    = w_v5[0] | w_v5[1];
    w_c6    = w_v5[0] ? {1'b0, w_c5[0]} : {1'b1, w_c5[1]};
    o_count = w_v6 ? w_c6 : 6'd56;
  end
endmodule

// File: rtl/norm_shift.sv
// Post-add normalization: two-stage pipeline that left-shifts on cancellation,
// right-shifts by one on carry-out, and adjusts the exponent to match.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and data stable until that edge. Ready may depend
// combinationally on the downstream ready, and there is no skid buffer.
module norm_shift
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] fs,
  input  logic [EXP_W-1:0] es,
  input  logic             ss,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] fn,
  output logic [EXP_W-1:0] en,
  output logic             sn,
  output logic             zero,
  output logic             ovf
);
  logic             r_s1_valid;
  s1_t              r_s1;
  logic             r_out_valid;
  s2_t              r_out;

  logic             w_s2_adv;
  logic [LZ_W-1:0]  w_lz;
  s2_t              w_s2;
  logic [11:0]      w_inc;
  logic [EXP_W-1:0] w_eff;
  logic [EXP_W-1:0] w_eff_m1;
  logic [LZ_W-1:0]  w_sh;
  logic [SIG_W-1:0] w_shifted;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  lzc56 u_lzc (
    .i_data  (fs[SIG_W-1:0]),
    .o_count (w_lz)
  );

  // S1 occupancy: refills whenever the stage can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // S1 payload: captured on accept only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1.fs    <= fs;
      r_s1.es    <= es;
      r_s1.ss    <= ss;
      r_s1.lz    <= w_lz;
      r_s1.carry <= fs[SUM_W-1];
    end
  end

  // S2 result: carry path first, then exact zero, then a clamped left shift.
  // es==0 behaves as exponent 1, so a denormal-range operand keeps en=0.
  always_comb begin
    w_s2      = '0;
    w_s2.sn   = r_s1.ss;
    w_inc     = {1'b0, r_s1.es} + 12'd1;
    w_eff     = (r_s1.es == '0) ? 11'd1 : r_s1.es;
    w_eff_m1  = w_eff - 11'd1;
    w_sh      = (w_eff_m1 < {5'd0, r_s1.lz}) ? w_eff_m1[LZ_W-1:0] : r_s1.lz;
    w_shifted = r_s1.fs[SIG_W-1:0] << w_sh;
    if (r_s1.carry) begin
      w_s2.fn  = {r_s1.fs[SUM_W-1:2], r_s1.fs[1] | r_s1.fs[0]};
      w_s2.en  = w_inc[EXP_W-1:0];
      w_s2.ovf = (w_inc == 12'(EXP_MAX));
    end else if (r_s1.fs == '0) begin
      w_s2.zero = 1'b1;
    end else begin
      w_s2.fn = w_shifted;
      w_s2.en = w_shifted[SIG_W-1] ? (w_eff - {5'd0, w_sh}) : '0;
    end
  end

  // S2 registers: advance when empty or when the rounder takes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_s2;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign fn        = r_out.fn;
  assign en        = r_out.en;
  assign sn        = r_out.sn;
  assign zero      = r_out.zero;
  assign ovf       = r_out.ovf;
endmodule

// File: tb/tb_norm_shift.sv
// Bench for norm_shift: behavioural model plus expected queue, directed
// corner cases, backpressure, mid-stream reset and randomized traffic.
module tb_norm_shift;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [56:0] fs = '0;
  logic [10:0] es = '0;
  logic        ss = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [55:0] fn;
  logic [10:0] en;
  logic        sn;
  logic        zero;
  logic        ovf;

  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic [69:0] exp_q[$];
  logic [69:0] dut_pk;
  logic [69:0] held;
  logic        held_v = 1'b0;
  logic        rnd_ready = 1'b0;

  norm_shift dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fs        (fs),
    .es        (es),
    .ss        (ss),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fn        (fn),
    .en        (en),
    .sn        (sn),
    .zero      (zero),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign dut_pk = {fn, en, sn, zero, ovf};

  // ---------------- model ----------------
  function automatic logic [69:0] pk(logic [55:0] f, logic [10:0] e, logic s, logic z, logic o);
    return {f, e, s, z, o};
  endfunction

  function automatic logic [69:0] model(logic [56:0] f, logic [10:0] e, logic s);
    int          lz;
    int          eff;
    int          sh;
    int          ex;
    logic [55:0] nf;
    logic [55:0] low;
    if (f[56]) begin
      nf = {f[56:2], f[1] | f[0]};
      ex = int'(e) + 1;
      return pk(nf, 11'(ex % 2048), s, 1'b0, ex == 2047);
    end
    if (f == 57'd0) return pk(56'd0, 11'd0, s, 1'b1, 1'b0);
    low = f[55:0];
    lz = 0;
    while (lz < 56 && !low[55-lz]) lz++;
    eff = (e == 11'd0) ? 1 : int'(e);
    sh = (lz < eff - 1) ? lz : eff - 1;
    nf = low << sh;
    ex = nf[55] ? eff - sh : 0;
    return pk(nf, 11'(ex), s, 1'b0, 1'b0);
  endfunction

  task automatic chk(string name, logic [69:0] act, logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 70'(out_valid), 70'(1));
        chk("stall_hold", dut_pk, held);
      end
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held   = dut_pk;
        held_v = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h want none", dut_pk);
        end else begin
          chk("result", dut_pk, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(fs, es, ss));
        acc_cnt++;
      end
    end
  end

  // Random downstream readiness while enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  // Drives one operand, returning one cycle after it is accepted.
  // in_valid is left high so back-to-back sends stay back-to-back.
  task automatic send(logic [56:0] f, logic [10:0] e, logic s);
    int n;
    fs = f;
    es = e;
    ss = s;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string name, logic [56:0] f, logic [10:0] e, logic s, logic [69:0] exp);
    fs = f;
    es = e;
    ss = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({name, "_early"}, 70'(out_valid), 70'(0));
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 70'(out_valid), 70'(1));
    chk(name, dut_pk, exp);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(posedge clk);
    end
    #1;
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d queued want 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 70'(out_valid), 70'(0));
    chk("rst_in_ready", 70'(in_ready), 70'(1));
  endtask

  function automatic logic [56:0] gen_fs();
    logic [63:0] r;
    logic [55:0] r56;
    r = {$urandom, $urandom};
    r56 = r[55:0];
    case ($urandom_range(0, 5))
      0: return {1'b1, r56};
      1: return 57'd0;
      2: return {1'b0, r56 >> $urandom_range(0, 55)};
      3: return 57'd1 << $urandom_range(0, 55);
      default: return {1'b0, r56};
    endcase
  endfunction

  function automatic logic [10:0] gen_es();
    case ($urandom_range(0, 5))
      0: return 11'd0;
      1: return 11'($urandom_range(1, 6));
      2: return 11'd2046;
      3: return 11'd2047;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [56:0] b56;
    logic [55:0] b55;
    int          base;
    b56 = 57'd1;
    b55 = 56'd1;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_out_valid", 70'(out_valid), 70'(0));
    chk("reset_in_ready", 70'(in_ready), 70'(1));
    chk("reset_outputs", dut_pk, 70'(0));

    // Pin the model against hand-computed values.
    chk("model_norm", model(b56 << 55, 11'h3FF, 1'b0), pk(b55 << 55, 11'h3FF, 1'b0, 1'b0, 1'b0));
    chk("model_carry", model((b56 << 56) | b56, 11'h3FF, 1'b0), pk((b55 << 55) | b55, 11'h400, 1'b0, 1'b0, 1'b0));
    chk("model_cancel", model(b56 << 10, 11'h3FF, 1'b0), pk(b55 << 55, 11'h3D2, 1'b0, 1'b0, 1'b0));
    chk("model_denorm", model(b56 << 10, 11'd5, 1'b0), pk(b55 << 14, 11'd0, 1'b0, 1'b0, 1'b0));
    chk("model_zero", model(57'd0, 11'h400, 1'b1), pk(56'd0, 11'd0, 1'b1, 1'b1, 1'b0));

    // Directed corner cases through the DUT.
    out_ready = 1'b1;
    directed("already_norm", b56 << 55, 11'h3FF, 1'b0, pk(b55 << 55, 11'h3FF, 1'b0, 1'b0, 1'b0));
    directed("carry_sticky", (b56 << 56) | b56, 11'h3FF, 1'b0, pk((b55 << 55) | b55, 11'h400, 1'b0, 1'b0, 1'b0));
    directed("carry_ovf", b56 << 56, 11'h7FE, 1'b1, pk(b55 << 55, 11'h7FF, 1'b1, 1'b0, 1'b1));
    directed("cancel", b56 << 10, 11'h3FF, 1'b0, pk(b55 << 55, 11'h3D2, 1'b0, 1'b0, 1'b0));
    directed("denorm_clamp", b56 << 10, 11'd5, 1'b0, pk(b55 << 14, 11'd0, 1'b0, 1'b0, 1'b0));
    directed("es0_norm", b56 << 55, 11'd0, 1'b0, pk(b55 << 55, 11'd1, 1'b0, 1'b0, 1'b0));
    directed("exact_zero", 57'd0, 11'h400, 1'b1, pk(56'd0, 11'd0, 1'b1, 1'b1, 1'b0));
    drain();

    // Backpressure: 5 back-to-back ops, out_ready low for 3 cycles.
    base = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(gen_fs(), gen_es(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", 70'(acc_cnt - base), 70'(2));
        chk("bp_in_ready", 70'(in_ready), 70'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_out", 70'(acc_cnt - base), 70'(5));

    // Reset with operands in flight: nothing stale may appear afterwards.
    out_ready = 1'b0;
    send(gen_fs(), gen_es(), 1'b0);
    send(gen_fs(), gen_es(), 1'b1);
    in_valid = 1'b0;
    pulse_reset();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", 70'(out_valid), 70'(0));
    send(b56 << 20, 11'h200, 1'b0);
    drain();

    // Randomized traffic with random backpressure and one mid-stream reset.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      if (i == 200) pulse_reset();
      send(gen_fs(), gen_es(), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
